uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter_pkg.sv | 28 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 47 ++++
 rtl/uart_tx_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arb_pkg
// Purpose  : Shared types and default constants for the UART TX arbiter.
//            Holds the arbiter state encoding, the default geometry
//            (requester count, byte width, burst limit) and the width of
//            the per-grant burst counter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_tx_arb_pkg;

  localparam int c_DEF_NUM_REQ   = 4;
  localparam int c_DEF_DATA_W    = 8;
  localparam int c_DEF_MAX_BURST = 4;

  // Wide enough for burst limits up to 15.
  localparam int c_BURST_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    WAIT = 2'd3
  } state_t;

endpackage : uart_tx_arb_pkg
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker. Returns the first asserted
//            bit of the valid vector at or after the pointer, wrapping
//            modulo NUM_REQ (non-power-of-2 counts supported).
// Ports    : i_valid    - request vector
//            i_ptr      - round-robin start index (must be < NUM_REQ)
//            o_anyValid - at least one request asserted
//            o_pick     - winning index (0 when none valid)
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = c_DEF_NUM_REQ,
  parameter int IDX_W   = $clog2(c_DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_anyValid,
  output logic [IDX_W-1:0]   o_pick
);

  // One extra bit: ptr + offset stays below 2*NUM_REQ before wrapping.
  logic [IDX_W:0] w_sum;

  // Scan offsets from the far end down to 0 so the nearest valid
  // requester to the pointer is the last one written and therefore wins.
  always_comb begin
    o_anyValid = 1'b0;
    o_pick     = '0;
    w_sum      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, i_ptr} + (IDX_W + 1)'(k);
      if (w_sum >= (IDX_W + 1)'(NUM_REQ)) begin
        w_sum = w_sum - (IDX_W + 1)'(NUM_REQ);
      end
      if (i_valid[w_sum[IDX_W-1:0]]) begin
        o_anyValid = 1'b1;
        o_pick     = w_sum[IDX_W-1:0];
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Shares one UART transmitter between NUM_REQ byte sources.
//            Round-robin grant, at most MAX_BURST bytes per grant, one
//            byte in flight at a time (valid/ready on both sides, tx_done
//            closes each byte).
// Ports    : clk, rst_n            - clock, async active-low reset
//            req_valid/data/last   - per-requester byte offer
//            req_ready             - one-hot byte acceptance
//            tx_valid/data/ready   - byte handoff to the UART shifter
//            tx_done               - shifter finished the stop bit
//            grant_id, busy        - current owner, arbiter not idle
//            err_timeout           - pulse on per-byte timeout abort
// Config   : `define UART_TX_ARB_TIMEOUT_EN enables the per-byte timeout
//            (TIMEOUT_CYCLES); otherwise err_timeout is tied 0.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ        = c_DEF_NUM_REQ,
  parameter int DATA_W         = c_DEF_DATA_W,
  parameter int MAX_BURST      = c_DEF_MAX_BURST,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_valid,
  output logic [DATA_W-1:0]          tx_data,
  input  logic                       tx_ready,
  input  logic                       tx_done,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       err_timeout
);

  localparam int c_IDX_W = $clog2(NUM_REQ);
  localparam logic [c_BURST_W-1:0] c_MAX_BURST = c_BURST_W'(MAX_BURST);

  generate
    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 15 ||
        TIMEOUT_CYCLES < 2) begin : g_paramCheck
      $error("uart_tx_arbiter: parameter out of range");
    end
  endgenerate

  state_t               r_state;
  logic [c_IDX_W-1:0]   r_ptr;
  logic [c_IDX_W-1:0]   r_grant;
  logic [c_BURST_W-1:0] r_burstCnt;
  logic [DATA_W-1:0]    r_holdData;
  logic                 r_holdLast;

  logic                 w_anyValid;
  logic [c_IDX_W-1:0]   w_pick;
  logic [c_IDX_W-1:0]   w_grantNext;
  logic [c_BURST_W-1:0] w_burstNext;
  logic                 w_ownerValid;
  logic [DATA_W-1:0]    w_ownerData;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int c_TO_W = $clog2(TIMEOUT_CYCLES);
  logic [c_TO_W-1:0] r_toCnt;
  logic              r_errTimeout;
  logic              w_toHit;
  assign w_toHit     = (r_toCnt == c_TO_W'(TIMEOUT_CYCLES - 1));
  assign err_timeout = r_errTimeout;
`else
  assign err_timeout = 1'b0;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (c_IDX_W)
  ) u_rrPick (
    .i_valid    (req_valid),
    .i_ptr      (r_ptr),
    .o_anyValid (w_anyValid),
    .o_pick     (w_pick)
  );

  // Explicit wrap so non-power-of-2 requester counts rotate correctly.
  assign w_grantNext  = (r_grant == c_IDX_W'(NUM_REQ - 1)) ? '0
                                                           : r_grant + c_IDX_W'(1);
  assign w_burstNext  = r_burstCnt + c_BURST_W'(1);
  assign w_ownerValid = req_valid[r_grant];

  always_comb begin
    w_ownerData = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant == c_IDX_W'(i)) begin
        w_ownerData = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // The handshake is only offered while the owner still has a byte, so a
  // source that withdraws during LOAD never sees a stray ready.
  always_comb begin
    req_ready = '0;
    if (r_state == LOAD && w_ownerValid) begin
      req_ready[r_grant] = 1'b1;
    end
  end

  assign tx_valid = (r_state == SEND);
  assign tx_data  = r_holdData;
  assign grant_id = r_grant;
  assign busy     = (r_state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_grant    <= '0;
      r_burstCnt <= '0;
      r_holdData <= '0;
      r_holdLast <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      r_toCnt      <= '0;
      r_errTimeout <= 1'b0;
`endif
    end else begin
`ifdef UART_TX_ARB_TIMEOUT_EN
      r_errTimeout <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_anyValid) begin
            r_grant    <= w_pick;
            r_burstCnt <= '0;
            r_state    <= LOAD;
          end
        end

        LOAD: begin
`ifdef UART_TX_ARB_TIMEOUT_EN
          r_toCnt <= '0;
`endif
          if (w_ownerValid) begin
            r_holdData <= w_ownerData;
            r_holdLast <= req_last[r_grant];
            r_state    <= SEND;
          end else begin
            r_ptr   <= w_grantNext;
            r_state <= IDLE;
          end
        end

        SEND: begin
`ifdef UART_TX_ARB_TIMEOUT_EN
          r_toCnt <= r_toCnt + c_TO_W'(1);
`endif
          if (tx_ready) begin
            r_state <= WAIT;
          end
`ifdef UART_TX_ARB_TIMEOUT_EN
          else if (w_toHit) begin
            r_errTimeout <= 1'b1;
            r_ptr        <= w_grantNext;
            r_state      <= IDLE;
          end
`endif
        end

        WAIT: begin
`ifdef UART_TX_ARB_TIMEOUT_EN
          r_toCnt <= r_toCnt + c_TO_W'(1);
`endif
          if (tx_done) begin
            r_burstCnt <= w_burstNext;
            // Keep the owner only mid-message, under the burst limit and
            // with another byte ready; otherwise hand over to the next one.
            if (!r_holdLast && (w_burstNext < c_MAX_BURST) && w_ownerValid) begin
              r_state <= LOAD;
            end else begin
              r_ptr   <= w_grantNext;
              r_state <= IDLE;
            end
          end
`ifdef UART_TX_ARB_TIMEOUT_EN
          else if (w_toHit) begin
            r_errTimeout <= 1'b1;
            r_ptr        <= w_grantNext;
            r_state      <= IDLE;
          end
`endif
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule : uart_tx_arbiter
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Directed self-checking bench for uart_tx_arbiter (4 requesters,
//            8-bit bytes, burst limit 4). Byte sources are fed from small
//            per-requester FIFOs; a UART stand-in accepts bytes and returns
//            tx_done five cycles after each accept.
// Ports    : none (top-level bench)
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int c_TO_CYC = 64;
`else
  localparam int c_TO_CYC = 1048576;
`endif

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        tx_done;
  logic [1:0]  grant_id;
  logic        busy;
  logic        err_timeout;

  int cmpCnt = 0;
  int errCnt = 0;
  bit autoDone = 1'b0;

  logic [8:0] srcMem [4][16];
  int         srcHead [4];
  int         srcTail [4];

  logic [7:0] logData [$];
  logic [1:0] logGrant [$];

  logic [7:0] e1Data  [3]  = '{8'h41, 8'h42, 8'h43};
  logic [7:0] e2Data  [8]  = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h01, 8'h11, 8'h21, 8'h31};
  logic [1:0] e2Grant [8]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
  logic [7:0] e3Data  [13] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2,
                               8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8, 8'hA9};
  logic [1:0] e3Grant [13] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2,
                               2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};

  uart_tx_arbiter #(
    .NUM_REQ        (4),
    .DATA_W         (8),
    .MAX_BURST      (4),
    .TIMEOUT_CYCLES (c_TO_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Byte sources: pop on a sampled handshake, present the next FIFO entry.
  initial begin
    logic [3:0] hs;
    hs        = '0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (hs[i]) srcHead[i]++;
        if (srcHead[i] < srcTail[i]) begin
          req_valid[i]         = 1'b1;
          req_data[i*8 +: 8]   = srcMem[i][srcHead[i]][7:0];
          req_last[i]          = srcMem[i][srcHead[i]][8];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  // UART stand-in: log each accepted byte, pulse tx_done 5 cycles later.
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (autoDone && rst_n && tx_valid && tx_ready) begin
        logData.push_back(tx_data);
        logGrant.push_back(grant_id);
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmpCnt++;
    assert (obs === exp)
    else begin
      errCnt++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    srcMem[r][srcTail[r]] = {l, d};
    srcTail[r]++;
  endtask

  task automatic clrAll;
    for (int i = 0; i < 4; i++) begin
      srcHead[i] = 0;
      srcTail[i] = 0;
    end
    logData.delete();
    logGrant.delete();
  endtask

  task automatic waitLog(input int n, input string tag);
    int c = 0;
    while (logData.size() < n && c < 800) begin
      tick;
      c++;
    end
    chk(tag, 32'(logData.size() >= n), 32'd1);
  endtask

  task automatic waitIdle(input string tag);
    int c = 0;
    while (busy !== 1'b0 && c < 200) begin
      tick;
      c++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic waitTxValid(input string tag);
    int c = 0;
    while (tx_valid !== 1'b1 && c < 200) begin
      tick;
      c++;
    end
    chk(tag, 32'(tx_valid), 32'd1);
  endtask

  task automatic waitTxDone(input string tag);
    int c = 0;
    while (tx_done !== 1'b1 && c < 200) begin
      tick;
      c++;
    end
    chk(tag, 32'(tx_done), 32'd1);
  endtask

  task automatic waitReqReady(input string tag);
    int c = 0;
    while (req_ready === 4'b0000 && c < 200) begin
      tick;
      c++;
    end
    chk(tag, 32'(req_ready != 4'b0000), 32'd1);
  endtask

  initial begin
    rst_n    = 1'b0;
    tx_ready = 1'b1;
    tick;
    tick;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_grant_id", 32'(grant_id), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err_timeout", 32'(err_timeout), 32'h0);
    rst_n = 1'b1;
    tick;

    // Single requester, 3-byte message.
    clrAll;
    autoDone = 1'b1;
    push(0, 8'h41, 1'b0);
    push(0, 8'h42, 1'b0);
    push(0, 8'h43, 1'b1);
    tick;
    chk("t1_idle_ready", 32'(req_ready), 32'h0);
    chk("t1_idle_busy", 32'(busy), 32'h0);
    tick;
    chk("t1_load_ready", 32'(req_ready), 32'h1);
    chk("t1_load_grant", 32'(grant_id), 32'h0);
    chk("t1_load_busy", 32'(busy), 32'h1);
    tick;
    chk("t1_send_valid", 32'(tx_valid), 32'h1);
    chk("t1_send_data", 32'(tx_data), 32'h41);
    chk("t1_send_ready", 32'(req_ready), 32'h0);
    waitTxDone("t1_done1_seen");
    chk("t1_wait_ready", 32'(req_ready), 32'h0);
    tick;
    chk("t1_done_to_ready", 32'(req_ready), 32'h1);
    waitLog(3, "t1_log_count");
    waitTxDone("t1_done3_seen");
    chk("t1_busy_at_done", 32'(busy), 32'h1);
    tick;
    chk("t1_busy_after_done", 32'(busy), 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("t1_data", 32'(logData[i]), 32'(e1Data[i]));
      chk("t1_grant", 32'(logGrant[i]), 32'h0);
    end

    // Fairness: pointer back to 0 after reset, 1-byte messages everywhere.
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    clrAll;
    for (int r = 0; r < 4; r++) begin
      push(r, 8'(r * 16), 1'b1);
      push(r, 8'(r * 16 + 1), 1'b1);
    end
    waitLog(8, "t2_log_count");
    for (int i = 0; i < 8; i++) begin
      chk("t2_data", 32'(logData[i]), 32'(e2Data[i]));
      chk("t2_grant", 32'(logGrant[i]), 32'(e2Grant[i]));
    end
    waitIdle("t2_idle");

    // Burst limit: req 1 streams 10 unterminated bytes against req 2.
    clrAll;
    for (int k = 0; k < 10; k++) push(1, 8'(8'hA0 + k), 1'b0);
    push(2, 8'hB0, 1'b0);
    push(2, 8'hB1, 1'b0);
    push(2, 8'hB2, 1'b1);
    waitLog(13, "t3_log_count");
    for (int i = 0; i < 13; i++) begin
      chk("t3_data", 32'(logData[i]), 32'(e3Data[i]));
      chk("t3_grant", 32'(logGrant[i]), 32'(e3Grant[i]));
    end
    waitIdle("t3_idle");

    // Backpressure: tx_ready low for 20 cycles in SEND.
    clrAll;
    tx_ready = 1'b0;
    push(0, 8'h5A, 1'b1);
    waitTxValid("t4_send_reached");
    for (int i = 0; i < 20; i++) begin
      chk("t4_hold", {22'h0, tx_valid, tx_data, req_ready}, {22'h0, 1'b1, 8'h5A, 4'h0});
      tick;
    end
    tx_ready = 1'b1;
    tick;
    chk("t4_accepted", 32'(tx_valid), 32'h0);
    chk("t4_log_count", 32'(logData.size()), 32'd1);
    chk("t4_log_data", 32'(logData[0]), 32'h5A);
    waitIdle("t4_idle");

    // Reset during WAIT of requester 3.
    clrAll;
    autoDone = 1'b0;
    push(3, 8'h33, 1'b1);
    waitTxValid("t5_send_reached");
    tick;
    chk("t5_wait_grant", 32'(grant_id), 32'h3);
    chk("t5_wait_busy", 32'(busy), 32'h1);
    chk("t5_wait_txvalid", 32'(tx_valid), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_req_ready", 32'(req_ready), 32'h0);
    chk("t5_rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("t5_rst_tx_data", 32'(tx_data), 32'h0);
    chk("t5_rst_grant", 32'(grant_id), 32'h0);
    chk("t5_rst_busy", 32'(busy), 32'h0);
    push(0, 8'h0A, 1'b1);
    push(3, 8'h3B, 1'b1);
    autoDone = 1'b1;
    tick;
    tick;
    rst_n = 1'b1;
    waitReqReady("t5_regrant");
    chk("t5_regrant_id", 32'(grant_id), 32'h0);
    chk("t5_regrant_ready", 32'(req_ready), 32'h1);
    waitLog(2, "t5_log_count");
    chk("t5_data0", 32'(logData[0]), 32'h0A);
    chk("t5_grant0", 32'(logGrant[0]), 32'h0);
    chk("t5_data1", 32'(logData[1]), 32'h3B);
    chk("t5_grant1", 32'(logGrant[1]), 32'h3);
    waitIdle("t5_idle");

`ifdef UART_TX_ARB_TIMEOUT_EN
    // Timeout: tx_done never arrives for requester 1.
    clrAll;
    autoDone = 1'b0;
    push(1, 8'h71, 1'b1);
    push(2, 8'h72, 1'b1);
    waitTxValid("t6_send_reached");
    chk("t6_grant", 32'(grant_id), 32'h1);
    begin
      int n = 0;
      while (err_timeout !== 1'b1 && n < 200) begin
        tick;
        n++;
      end
      chk("t6_timeout_cycles", 32'(n), 32'd64);
    end
    tick;
    chk("t6_pulse_width", 32'(err_timeout), 32'h0);
    waitReqReady("t6_next_grant");
    chk("t6_next_grant_id", 32'(grant_id), 32'h2);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
    $finish;
  end

endmodule : tb_uart_tx_arbiter
`default_nettype wire
